// File: rtl/rcc_rst_seq_pkg.sv
// Shared definitions for the RCC reset/clock-enable sequencer: per-domain FSM
// state encoding and default duration/delay constants reused by the RCC top.
package rcc_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT   = 3'd0,
        ST_WAIT_PAR = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_RUN      = 3'd3,
        ST_GATE     = 3'd4
    } dom_state_e;

    localparam int unsigned DEF_RST_DUR = 10;
    localparam int unsigned DEF_CLK_DLY = 8;

endpackage

// File: rtl/rcc_rst_seq_dom.sv
// Single-domain reset/clock-enable sequencer: one FSM plus a shared
// duration/delay counter. Outputs are registered from the next state.
module rcc_dom_seq
    import rcc_rst_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] dur,
    input  logic [CNT_W-1:0] dly,
    input  logic             chain_en,
    input  logic             par_ready,
    input  logic             req,
    output logic             rst_n,
    output logic             clk_en,
    output logic             ready
);

    dom_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dur_term;
    logic [CNT_W-1:0] dly_term;
    logic             par_lost;

    // Zero durations behave as one cycle; >= compare keeps the counter from wrapping.
    assign dur_term = (dur == '0) ? '0 : dur - CNT_W'(1);
    assign dly_term = (dly == '0) ? '0 : dly - CNT_W'(1);
    assign par_lost = chain_en & ~par_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q >= dur_term) begin
                    cnt_d   = '0;
                    state_d = chain_en ? ST_WAIT_PAR : ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_PAR: begin
                cnt_d = '0;
                if (req) begin
                    state_d = ST_ASSERT;
                end else if (par_ready) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (req || par_lost) begin
                    cnt_d   = '0;
                    state_d = ST_ASSERT;
                end else if (cnt_q >= dly_term) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Clock is always gated for one cycle before reset re-asserts.
                if (req || par_lost) begin
                    state_d = ST_GATE;
                end
            end
            ST_GATE: begin
                cnt_d   = '0;
                state_d = ST_ASSERT;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rst_n   <= 1'b0;
            clk_en  <= 1'b0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n   <= (state_d == ST_RELEASE) || (state_d == ST_RUN) || (state_d == ST_GATE);
            clk_en  <= (state_d == ST_RUN);
            ready   <= (state_d == ST_RUN);
        end
    end

endmodule

// File: rtl/rcc_rst_seq.sv
// N-domain reset/clock-enable sequencer for the RCC: one rcc_dom_seq per domain,
// optionally chained so each domain releases only after its parent is running.
module rcc_rst_seq
    import rcc_rst_seq_pkg::*;
#(
    parameter int unsigned               N_DOM   = 4,
    parameter int unsigned               CNT_W   = 8,
    parameter logic [N_DOM*CNT_W-1:0]    RST_DUR = {N_DOM{CNT_W'(DEF_RST_DUR)}},
    parameter logic [N_DOM*CNT_W-1:0]    CLK_DLY = {N_DOM{CNT_W'(DEF_CLK_DLY)}},
    parameter logic                      CHAIN   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DOM-1:0] dom_rst_req,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic [N_DOM-1:0] dom_clk_en,
    output logic [N_DOM-1:0] dom_ready,
    output logic             seq_busy
);

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        localparam logic CHAIN_EN = CHAIN && (i > 0);
        logic par_ready;

        if (i == 0) begin : g_root
            assign par_ready = 1'b1;
        end else begin : g_child
            assign par_ready = dom_ready[i-1];
        end

        rcc_dom_seq #(
            .CNT_W (CNT_W)
        ) u_dom (
            .clk       (clk),
            .rst       (rst),
            .dur       (RST_DUR[i*CNT_W +: CNT_W]),
            .dly       (CLK_DLY[i*CNT_W +: CNT_W]),
            .chain_en  (CHAIN_EN),
            .par_ready (par_ready),
            .req       (dom_rst_req[i]),
            .rst_n     (dom_rst_n[i]),
            .clk_en    (dom_clk_en[i]),
            .ready     (dom_ready[i])
        );
    end

    assign seq_busy = ~&dom_ready;

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Directed bench for rcc_rst_seq: independent, chained and minimum-duration
// configurations driven from checkpoint tables plus short hand-written sequences.
module tb_rcc_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_a, req_b, req_c;
    logic [1:0] a_rst_n, a_clk_en, a_ready;
    logic [1:0] b_rst_n, b_clk_en, b_ready;
    logic [1:0] c_rst_n, c_clk_en, c_ready;
    logic       a_busy, b_busy, c_busy;

    // A: independent, dur 10 / dly 8
    rcc_rst_seq #(
        .N_DOM   (2),
        .CNT_W   (8),
        .RST_DUR ({2{8'd10}}),
        .CLK_DLY ({2{8'd8}}),
        .CHAIN   (1'b0)
    ) u_a (
        .clk (clk), .rst (rst), .dom_rst_req (req_a),
        .dom_rst_n (a_rst_n), .dom_clk_en (a_clk_en), .dom_ready (a_ready), .seq_busy (a_busy)
    );

    // B: chained, dur 4 / dly 2
    rcc_rst_seq #(
        .N_DOM   (2),
        .CNT_W   (8),
        .RST_DUR ({2{8'd4}}),
        .CLK_DLY ({2{8'd2}}),
        .CHAIN   (1'b1)
    ) u_b (
        .clk (clk), .rst (rst), .dom_rst_req (req_b),
        .dom_rst_n (b_rst_n), .dom_clk_en (b_clk_en), .dom_ready (b_ready), .seq_busy (b_busy)
    );

    // C: dom1 dur 1, dom0 dur 0 (treated as 1), no clock delay
    rcc_rst_seq #(
        .N_DOM   (2),
        .CNT_W   (8),
        .RST_DUR ({8'd1, 8'd0}),
        .CLK_DLY ({8'd0, 8'd0}),
        .CHAIN   (1'b0)
    ) u_c (
        .clk (clk), .rst (rst), .dom_rst_req (req_c),
        .dom_rst_n (c_rst_n), .dom_clk_en (c_clk_en), .dom_ready (c_ready), .seq_busy (c_busy)
    );

    // exp = {rst_n[1:0], clk_en[1:0], ready[1:0], busy}; req applied after the check
    typedef struct {
        int         edge_n;
        logic [1:0] req;
        logic [6:0] exp;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    int   checks   = 0;
    int   failures = 0;
    int   ecnt     = 0;

    function automatic logic [6:0] outs(input int sel);
        case (sel)
            0:       return {a_rst_n, a_clk_en, a_ready, a_busy};
            1:       return {b_rst_n, b_clk_en, b_ready, b_busy};
            default: return {c_rst_n, c_clk_en, c_ready, c_busy};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @edge %0d: got %b expected %b", name, ecnt, act, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        step();
        step();
        rst  = 1'b0;
        ecnt = 0;
    endtask

    task automatic add(input int sel, input int e, input logic [1:0] rq, input logic [1:0] rn,
                       input logic [1:0] ce, input logic [1:0] rd, input logic bz);
        vec_t v;
        v.edge_n = e;
        v.req    = rq;
        v.exp    = {rn, ce, rd, bz};
        if (sel == 0) tab_a.push_back(v);
        else          tab_b.push_back(v);
    endtask

    task automatic run_table(input int sel, input string tag);
        vec_t v;
        int   n;
        n = (sel == 0) ? tab_a.size() : tab_b.size();
        for (int i = 0; i < n; i++) begin
            v = (sel == 0) ? tab_a[i] : tab_b[i];
            while (ecnt < v.edge_n && ecnt < 1000) step();
            check($sformatf("%s[%0d]", tag, i), outs(sel), v.exp);
            if (sel == 0) req_a = v.req;
            else          req_b = v.req;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Independent release, then a one-cycle request on domain 1 at edge 26.
        add(0,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(0,  9, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(0, 10, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        add(0, 17, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        add(0, 18, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0);
        add(0, 25, 2'b10, 2'b11, 2'b11, 2'b11, 1'b0);
        add(0, 26, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(0, 27, 2'b00, 2'b01, 2'b01, 2'b01, 1'b1);
        add(0, 36, 2'b00, 2'b01, 2'b01, 2'b01, 1'b1);
        add(0, 37, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(0, 44, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(0, 45, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0);

        // Chained release, then a one-cycle request on domain 0 at edge 11 cascading to domain 1.
        add(1,  0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(1,  3, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(1,  4, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1,  5, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1,  6, 2'b00, 2'b01, 2'b01, 2'b01, 1'b1);
        add(1,  7, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(1,  8, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(1,  9, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0);
        add(1, 10, 2'b01, 2'b11, 2'b11, 2'b11, 1'b0);
        add(1, 11, 2'b00, 2'b11, 2'b10, 2'b10, 1'b1);
        add(1, 12, 2'b00, 2'b10, 2'b00, 2'b00, 1'b1);
        add(1, 13, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(1, 15, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        add(1, 16, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1, 17, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        add(1, 18, 2'b00, 2'b01, 2'b01, 2'b01, 1'b1);
        add(1, 19, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(1, 20, 2'b00, 2'b11, 2'b01, 2'b01, 1'b1);
        add(1, 21, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0);

        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        req_c = '0;

        do_reset();
        run_table(0, "indep");

        // rst during RELEASE: reset values on the next edge, then an identical restart.
        do_reset();
        repeat (11) step();
        check("pre_rst_release", outs(0), {2'b11, 2'b00, 2'b00, 1'b1});
        rst = 1'b1;
        step();
        check("mid_rst", outs(0), {2'b00, 2'b00, 2'b00, 1'b1});
        rst  = 1'b0;
        ecnt = 0;
        run_table(0, "restart");

        do_reset();
        run_table(1, "chain");

        // Minimum durations, then a request held for 20 cycles.
        do_reset();
        check("min_reset", outs(2), {2'b00, 2'b00, 2'b00, 1'b1});
        step();
        check("min_e1", outs(2), {2'b11, 2'b00, 2'b00, 1'b1});
        step();
        check("min_e2", outs(2), {2'b11, 2'b11, 2'b11, 1'b0});
        req_c = 2'b11;
        step();
        check("min_gate", outs(2), {2'b11, 2'b00, 2'b00, 1'b1});
        for (int k = 0; k < 19; k++) begin
            step();
            check($sformatf("min_hold%0d", k), outs(2), {2'b00, 2'b00, 2'b00, 1'b1});
        end
        req_c = 2'b00;
        step();
        check("min_rel", outs(2), {2'b11, 2'b00, 2'b00, 1'b1});
        step();
        check("min_run", outs(2), {2'b11, 2'b11, 2'b11, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
